dispatcher_output_rr: RTL and testbench

- Parametrised N-channel packet merger that replaces the fixed two-source dispatcher output stage. It feeds a single RDMA-side packet/valid interface.
- Each channel has its own packet FIFO and per-packet valid-flag FIFO.
- Whole packets are granted round-robin. Packets whose valid flag is 0 are drained internally and never forwarded.
- Mid-packet underrun stalls output; the block never emits garbage words.

---
 rtl/dispatcher_output_rr.sv | 241 ++++++++++++++++++++++++
 tb/tb_dispatcher_output_rr.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher_output_rr.sv
// N-channel round-robin packet merger feeding a single RDMA packet/valid interface.
// Define DISPATCHER_STATS_EN to add per-channel forwarded/dropped packet counters.
module dispatcher_output_rr #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 134,
  parameter int PKT_AW   = 8,
  parameter int VLD_AW   = 6,
  parameter int AFULL_TH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_pkt_wr,
  input  logic [NUM_CH*DATA_W-1:0] in_pkt,
  input  logic [NUM_CH-1:0]        in_valid_wr,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        out_pkt_almostfull,
  output logic                     out_rdma_pkt_wr,
  output logic [DATA_W-1:0]        out_rdma_pkt,
  output logic                     out_rdma_valid_wr,
  output logic                     out_rdma_valid,
  input  logic                     in_rdma_pkt_almostfull
`ifdef DISPATCHER_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]     stat_fwd_cnt,
  output logic [NUM_CH*32-1:0]     stat_drop_cnt
`endif
);

  localparam int PTR_W     = $clog2(NUM_CH);
  localparam int PKT_DEPTH = 1 << PKT_AW;
  localparam int VLD_DEPTH = 1 << VLD_AW;
  localparam logic [1:0] MK_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DISCARD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;

  logic [NUM_CH-1:0]  w_pkt_empty;
  logic [NUM_CH-1:0]  w_vld_empty;
  logic [NUM_CH-1:0]  w_vld_head;
  logic [NUM_CH-1:0]  w_pkt_pop;
  logic [NUM_CH-1:0]  w_vld_pop;
  logic [DATA_W-1:0]  w_pkt_head [NUM_CH];

  logic               w_grant_found;
  logic [PTR_W-1:0]   w_grant_ch;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_cand;

  logic [DATA_W-1:0]  w_cur_word;
  logic [1:0]         w_cur_mark;

  logic               w_out_wr_nxt;
  logic [DATA_W-1:0]  w_out_pkt_nxt;
  logic               w_out_vwr_nxt;
  logic               w_fwd_inc;
  logic               w_drop_inc;

  logic               r_out_wr;
  logic [DATA_W-1:0]  r_out_pkt;
  logic               r_out_vwr;

  // Per-channel show-ahead packet and valid-flag FIFOs; writes to a full FIFO are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_W-1:0] r_pkt_mem [PKT_DEPTH];
    logic [PKT_AW-1:0] r_pkt_wptr;
    logic [PKT_AW-1:0] r_pkt_rptr;
    logic [PKT_AW:0]   r_pkt_cnt;
    logic              w_pkt_we;

    logic              r_vld_mem [VLD_DEPTH];
    logic [VLD_AW-1:0] r_vld_wptr;
    logic [VLD_AW-1:0] r_vld_rptr;
    logic [VLD_AW:0]   r_vld_cnt;
    logic              w_vld_we;

    assign w_pkt_we              = in_pkt_wr[g] && !r_pkt_cnt[PKT_AW];
    assign w_pkt_empty[g]        = (r_pkt_cnt == '0);
    assign w_pkt_head[g]         = r_pkt_mem[r_pkt_rptr];
    assign out_pkt_almostfull[g] = (int'(r_pkt_cnt) >= AFULL_TH);

    assign w_vld_we       = in_valid_wr[g] && !r_vld_cnt[VLD_AW];
    assign w_vld_empty[g] = (r_vld_cnt == '0);
    assign w_vld_head[g]  = r_vld_mem[r_vld_rptr];

    always_ff @(posedge clk) begin
      if (w_pkt_we) r_pkt_mem[r_pkt_wptr] <= in_pkt[g*DATA_W +: DATA_W];
      if (w_vld_we) r_vld_mem[r_vld_wptr] <= in_valid[g];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_pkt_wptr <= '0;
        r_pkt_rptr <= '0;
        r_pkt_cnt  <= '0;
        r_vld_wptr <= '0;
        r_vld_rptr <= '0;
        r_vld_cnt  <= '0;
      end else begin
        if (w_pkt_we)     r_pkt_wptr <= r_pkt_wptr + PKT_AW'(1);
        if (w_pkt_pop[g]) r_pkt_rptr <= r_pkt_rptr + PKT_AW'(1);
        case ({w_pkt_we, w_pkt_pop[g]})
          2'b10:   r_pkt_cnt <= r_pkt_cnt + (PKT_AW+1)'(1);
          2'b01:   r_pkt_cnt <= r_pkt_cnt - (PKT_AW+1)'(1);
          default: r_pkt_cnt <= r_pkt_cnt;
        endcase
        if (w_vld_we)     r_vld_wptr <= r_vld_wptr + VLD_AW'(1);
        if (w_vld_pop[g]) r_vld_rptr <= r_vld_rptr + VLD_AW'(1);
        case ({w_vld_we, w_vld_pop[g]})
          2'b10:   r_vld_cnt <= r_vld_cnt + (VLD_AW+1)'(1);
          2'b01:   r_vld_cnt <= r_vld_cnt - (VLD_AW+1)'(1);
          default: r_vld_cnt <= r_vld_cnt;
        endcase
      end
    end
  end

  // Round-robin search starts one past the last granted channel and wraps back onto it.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_ch    = r_ptr;
    w_sum         = '0;
    w_cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_CH)) w_sum = w_sum - (PTR_W+1)'(NUM_CH);
      w_cand = w_sum[PTR_W-1:0];
      if (!w_grant_found && !w_vld_empty[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_ch    = w_cand;
      end
    end
  end

  assign w_cur_word = w_pkt_head[r_ptr];
  assign w_cur_mark = w_cur_word[DATA_W-1 -: 2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= PTR_W'(NUM_CH - 1);
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Backpressure is only honoured at the grant; once inside a packet it runs to the tail.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_pkt_pop     = '0;
    w_vld_pop     = '0;
    w_out_wr_nxt  = 1'b0;
    w_out_pkt_nxt = '0;
    w_out_vwr_nxt = 1'b0;
    w_fwd_inc     = 1'b0;
    w_drop_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!in_rdma_pkt_almostfull && w_grant_found) begin
          w_ptr_nxt             = w_grant_ch;
          w_vld_pop[w_grant_ch] = 1'b1;
          w_state_nxt           = w_vld_head[w_grant_ch] ? ST_SEND : ST_DISCARD;
        end
      end
      ST_SEND: begin
        if (!w_pkt_empty[r_ptr]) begin
          w_pkt_pop[r_ptr] = 1'b1;
          w_out_wr_nxt     = 1'b1;
          w_out_pkt_nxt    = w_cur_word;
          if (w_cur_mark == MK_TAIL) begin
            w_out_vwr_nxt = 1'b1;
            w_fwd_inc     = 1'b1;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (!w_pkt_empty[r_ptr]) begin
          w_pkt_pop[r_ptr] = 1'b1;
          if (w_cur_mark == MK_TAIL) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_wr  <= 1'b0;
      r_out_pkt <= '0;
      r_out_vwr <= 1'b0;
    end else begin
      r_out_wr  <= w_out_wr_nxt;
      r_out_pkt <= w_out_pkt_nxt;
      r_out_vwr <= w_out_vwr_nxt;
    end
  end

  assign out_rdma_pkt_wr   = r_out_wr;
  assign out_rdma_pkt      = r_out_pkt;
  assign out_rdma_valid_wr = r_out_vwr;
  assign out_rdma_valid    = r_out_vwr;

`ifdef DISPATCHER_STATS_EN
  logic [31:0] r_fwd_cnt  [NUM_CH];
  logic [31:0] r_drop_cnt [NUM_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_fwd_cnt[i]  <= '0;
        r_drop_cnt[i] <= '0;
      end
    end else begin
      if (w_fwd_inc)  r_fwd_cnt[r_ptr]  <= r_fwd_cnt[r_ptr] + 32'd1;
      if (w_drop_inc) r_drop_cnt[r_ptr] <= r_drop_cnt[r_ptr] + 32'd1;
    end
  end

  for (genvar s = 0; s < NUM_CH; s++) begin : g_stat
    assign stat_fwd_cnt[s*32 +: 32]  = r_fwd_cnt[s];
    assign stat_drop_cnt[s*32 +: 32] = r_drop_cnt[s];
  end
`else
  logic w_stats_unused;
  assign w_stats_unused = w_fwd_inc | w_drop_inc;
`endif

endmodule

// File: tb/tb_dispatcher_output_rr.sv
// Directed self-checking bench for dispatcher_output_rr (default parameters).
// Stat counter checks are compiled in only when DISPATCHER_STATS_EN is defined.
module tb_dispatcher_output_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 134;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_CH-1:0]        in_pkt_wr;
  logic [NUM_CH*DATA_W-1:0] in_pkt;
  logic [NUM_CH-1:0]        in_valid_wr;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        out_pkt_almostfull;
  logic                     out_rdma_pkt_wr;
  logic [DATA_W-1:0]        out_rdma_pkt;
  logic                     out_rdma_valid_wr;
  logic                     out_rdma_valid;
  logic                     in_rdma_pkt_almostfull;
`ifdef DISPATCHER_STATS_EN
  logic [NUM_CH*32-1:0]     stat_fwd_cnt;
  logic [NUM_CH*32-1:0]     stat_drop_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dispatcher_output_rr dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_pkt_wr              (in_pkt_wr),
    .in_pkt                 (in_pkt),
    .in_valid_wr            (in_valid_wr),
    .in_valid               (in_valid),
    .out_pkt_almostfull     (out_pkt_almostfull),
    .out_rdma_pkt_wr        (out_rdma_pkt_wr),
    .out_rdma_pkt           (out_rdma_pkt),
    .out_rdma_valid_wr      (out_rdma_valid_wr),
    .out_rdma_valid         (out_rdma_valid),
    .in_rdma_pkt_almostfull (in_rdma_pkt_almostfull)
`ifdef DISPATCHER_STATS_EN
    ,
    .stat_fwd_cnt           (stat_fwd_cnt),
    .stat_drop_cnt          (stat_drop_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] mk_word(input logic [1:0] mk, input int ch, input int seq);
    logic [DATA_W-1:0] w;
    w = '0;
    w[DATA_W-1 -: 2] = mk;
    w[100:69] = 32'hDEAD_BEEF ^ 32'(seq * 7 + ch);
    w[15:8] = 8'(ch);
    w[7:0] = 8'(seq);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_pkt_wr   = '0;
    in_pkt      = '0;
    in_valid_wr = '0;
    in_valid    = '0;
  endtask

  task automatic drive_word(input int ch, input logic [DATA_W-1:0] w);
    in_pkt[ch*DATA_W +: DATA_W] = w;
    in_pkt_wr[ch] = 1'b1;
  endtask

  task automatic drive_flag(input int ch, input logic v);
    in_valid[ch]    = v;
    in_valid_wr[ch] = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    in_rdma_pkt_almostfull = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Advance until an output word appears or the budget runs out; n = edges waited.
  task automatic wait_wr(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_rdma_pkt_wr && n < limit);
  endtask

  task automatic test_reset();
    clear_inputs();
    in_rdma_pkt_almostfull = 1'b0;
    reset = 1'b0;
    tick();
    tests_run++;
    if ({out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_valid} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 000", {out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_valid});
    end
    tests_run++;
    if (out_rdma_pkt !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pkt: got %h expected 0", out_rdma_pkt);
    end
    tests_run++;
    if (out_pkt_almostfull !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_afull: got %b expected 0000", out_pkt_almostfull);
    end
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (out_rdma_pkt_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle_wr: got %b expected 0", out_rdma_pkt_wr);
    end
  endtask

  task automatic test_single_packet();
    logic [DATA_W-1:0] w [3];
    int n;
    apply_reset();
    w[0] = mk_word(2'b01, 0, 0);
    w[1] = mk_word(2'b11, 0, 1);
    w[2] = mk_word(2'b10, 0, 2);
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      drive_word(0, w[k]);
      tick();
    end
    clear_inputs();
    drive_flag(0, 1'b1);
    tick();
    clear_inputs();
    wait_wr(20, n);
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: got %0d edges expected 2", n);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      tests_run++;
      if (out_rdma_pkt_wr !== 1'b1 || out_rdma_pkt !== w[k] ||
          out_rdma_valid_wr !== (k == 2) || out_rdma_valid !== (k == 2)) begin
        tests_failed++;
        $display("[TB] FAIL single_word%0d: got wr=%b vwr=%b v=%b pkt=%h expected wr=1 vwr=%0d pkt=%h",
                 k, out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_valid, out_rdma_pkt, (k == 2), w[k]);
      end
    end
    tick();
    tests_run++;
    if (out_rdma_pkt_wr !== 1'b0 || out_rdma_valid_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_after: got wr=%b vwr=%b expected 0 0", out_rdma_pkt_wr, out_rdma_valid_wr);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int slot;
    int pos;
    logic [DATA_W-1:0] exp_w;
    apply_reset();
    clear_inputs();
    for (int ch = 0; ch < NUM_CH; ch++) drive_word(ch, mk_word(2'b01, ch, 0));
    tick();
    clear_inputs();
    for (int ch = 0; ch < NUM_CH; ch++) drive_word(ch, mk_word(2'b10, ch, 1));
    tick();
    clear_inputs();
    for (int ch = 0; ch < NUM_CH; ch++) drive_flag(ch, 1'b1);
    tick();
    clear_inputs();
    wait_wr(20, n);
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("[TB] FAIL rr_latency: got %0d edges expected 2", n);
    end
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      slot = i / 3;
      pos = i % 3;
      tests_run++;
      if (pos == 2) begin
        if (out_rdma_pkt_wr !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rr_gap%0d: got wr=%b expected 0", i, out_rdma_pkt_wr);
        end
      end else begin
        exp_w = mk_word((pos == 0) ? 2'b01 : 2'b10, slot, pos);
        if (out_rdma_pkt_wr !== 1'b1 || out_rdma_pkt !== exp_w || out_rdma_valid_wr !== (pos == 1)) begin
          tests_failed++;
          $display("[TB] FAIL rr_cycle%0d: got wr=%b vwr=%b pkt=%h expected wr=1 vwr=%0d pkt=%h",
                   i, out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_pkt, (pos == 1), exp_w);
        end
      end
    end
    tick();
    tests_run++;
    if (out_rdma_pkt_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rr_drained: got wr=%b expected 0", out_rdma_pkt_wr);
    end
  endtask

  task automatic test_discard();
    logic [1:0] mk_a [4];
    logic [1:0] mk_b [3];
    logic [DATA_W-1:0] exp_b [3];
    int got;
    int nv;
    apply_reset();
    mk_a = '{2'b01, 2'b11, 2'b11, 2'b10};
    mk_b = '{2'b01, 2'b11, 2'b10};
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      drive_word(1, mk_word(mk_a[k], 1, k));
      if (k == 3) drive_flag(1, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      exp_b[k] = mk_word(mk_b[k], 1, 10 + k);
      clear_inputs();
      drive_word(1, exp_b[k]);
      if (k == 2) drive_flag(1, 1'b1);
      tick();
    end
    clear_inputs();
    got = 0;
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_rdma_pkt_wr) begin
        if (got < 3) begin
          tests_run++;
          if (out_rdma_pkt !== exp_b[got]) begin
            tests_failed++;
            $display("[TB] FAIL discard_word%0d: got %h expected %h", got, out_rdma_pkt, exp_b[got]);
          end
        end
        got++;
      end
      if (out_rdma_valid_wr) nv++;
    end
    tests_run++;
    if (got !== 3) begin
      tests_failed++;
      $display("[TB] FAIL discard_count: got %0d words expected 3", got);
    end
    tests_run++;
    if (nv !== 1) begin
      tests_failed++;
      $display("[TB] FAIL discard_vwr: got %0d valid strobes expected 1", nv);
    end
`ifdef DISPATCHER_STATS_EN
    tests_run++;
    if (stat_drop_cnt[32 +: 32] !== 32'd1 || stat_fwd_cnt[32 +: 32] !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL discard_stats: got drop=%0d fwd=%0d expected 1 1",
               stat_drop_cnt[32 +: 32], stat_fwd_cnt[32 +: 32]);
    end
`endif
  endtask

  task automatic test_underrun();
    logic wr_s [10];
    logic vw_s [10];
    logic [DATA_W-1:0] pk_s [10];
    logic [DATA_W-1:0] h;
    logic [DATA_W-1:0] t;
    apply_reset();
    h = mk_word(2'b01, 2, 0);
    t = mk_word(2'b10, 2, 1);
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      if (c == 0) begin
        drive_word(2, h);
        drive_flag(2, 1'b1);
      end
      if (c == 5) drive_word(2, t);
      tick();
      wr_s[c] = out_rdma_pkt_wr;
      vw_s[c] = out_rdma_valid_wr;
      pk_s[c] = out_rdma_pkt;
    end
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (wr_s[c] !== (c == 2 || c == 6)) begin
        tests_failed++;
        $display("[TB] FAIL underrun_wr%0d: got %b expected %0d", c, wr_s[c], (c == 2 || c == 6));
      end
    end
    tests_run++;
    if (pk_s[2] !== h || vw_s[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL underrun_head: got vwr=%b pkt=%h expected vwr=0 pkt=%h", vw_s[2], pk_s[2], h);
    end
    tests_run++;
    if (pk_s[6] !== t || vw_s[6] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL underrun_tail: got vwr=%b pkt=%h expected vwr=1 pkt=%h", vw_s[6], pk_s[6], t);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] mk_p [4];
    logic [DATA_W-1:0] w [4];
    int seen;
    int n;
    apply_reset();
    mk_p = '{2'b01, 2'b11, 2'b11, 2'b10};
    in_rdma_pkt_almostfull = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      w[k] = mk_word(mk_p[k], 3, 20 + k);
      clear_inputs();
      drive_word(3, w[k]);
      if (k == 3) drive_flag(3, 1'b1);
      tick();
      if (out_rdma_pkt_wr) seen++;
    end
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_rdma_pkt_wr) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold: got %0d words expected 0", seen);
    end
    in_rdma_pkt_almostfull = 1'b0;
    wait_wr(10, n);
    tests_run++;
    if (n !== 2 || out_rdma_pkt !== w[0]) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: got %0d edges pkt=%h expected 2 edges pkt=%h", n, out_rdma_pkt, w[0]);
    end
    in_rdma_pkt_almostfull = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      tests_run++;
      if (out_rdma_pkt_wr !== 1'b1 || out_rdma_pkt !== w[k] || out_rdma_valid_wr !== (k == 3)) begin
        tests_failed++;
        $display("[TB] FAIL bp_midpkt%0d: got wr=%b vwr=%b pkt=%h expected wr=1 vwr=%0d pkt=%h",
                 k, out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_pkt, (k == 3), w[k]);
      end
    end
    tick();
    tests_run++;
    if (out_rdma_pkt_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_end: got wr=%b expected 0", out_rdma_pkt_wr);
    end
    in_rdma_pkt_almostfull = 1'b0;
  endtask

  task automatic test_almostfull_reset();
    int n;
    int seen;
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      clear_inputs();
      drive_word(2, mk_word((k == 0) ? 2'b01 : 2'b11, 2, k));
      tick();
      tests_run++;
      if (out_pkt_almostfull !== {1'b0, (k + 1 >= 128), 2'b00}) begin
        tests_failed++;
        $display("[TB] FAIL afull_usedw%0d: got %b expected %b", k + 1, out_pkt_almostfull,
                 {1'b0, (k + 1 >= 128), 2'b00});
      end
    end
    clear_inputs();
    drive_flag(2, 1'b1);
    tick();
    clear_inputs();
    wait_wr(10, n);
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("[TB] FAIL afull_send_start: got %0d edges expected 2", n);
    end
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_valid} !== 3'b000 || out_rdma_pkt !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midsend_reset_out: got wr=%b vwr=%b v=%b pkt=%h expected all 0",
               out_rdma_pkt_wr, out_rdma_valid_wr, out_rdma_valid, out_rdma_pkt);
    end
    tests_run++;
    if (out_pkt_almostfull !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midsend_reset_afull: got %b expected 0000", out_pkt_almostfull);
    end
    tick();
    reset = 1'b1;
    tick();
    drive_flag(2, 1'b1);
    tick();
    clear_inputs();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_rdma_pkt_wr) seen++;
    end
    tests_run++;
    if (seen !== 0 || out_pkt_almostfull !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL postreset_empty: got %0d words afull=%b expected 0 words afull=0000",
               seen, out_pkt_almostfull);
    end
  endtask

  initial begin
    clear_inputs();
    in_rdma_pkt_almostfull = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_discard();
    test_underrun();
    test_backpressure();
    test_almostfull_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
